checksum_engine: RTL and testbench

- Parametrised checksum datapath that replaces the fixed 16×8 run-sum sequence inside the checksum HLSM.
- Walks a window of a synchronous-read RAM through a read port and accumulates words modulo 2^DATA_W.
- Two modes: generate returns the two's-complement checksum; verify also flags whether the window sums to zero.
- Reports busy cycles for the count display. The top-level HLSM drives start/mode/window and consumes done/checksum.

---
 rtl/checksum_engine_if.sv | 32 +++
 rtl/checksum_engine.sv | 134 +++++++++++++
 tb/tb_checksum_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/checksum_engine_if.sv
// Control and RAM read-port bundle for checksum_engine.
// slave = the engine, master = the HLSM plus RAM side that drives it.
interface checksum_engine_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [DATA_W-1:0] checksum;
    logic              sum_ok;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  start, abort, mode, base_addr, length, mem_rdata,
        output mem_rd_en, mem_addr, busy, done, aborted, checksum, sum_ok, cycle_count
    );

    modport master (
        output start, abort, mode, base_addr, length, mem_rdata,
        input  mem_rd_en, mem_addr, busy, done, aborted, checksum, sum_ok, cycle_count
    );
endinterface

// File: rtl/checksum_engine.sv
// Walks a RAM window through a synchronous-read port, sums words mod 2^DATA_W and
// returns the two's-complement checksum (generate) or a zero-sum flag (verify).
module checksum_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    checksum_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        DRN_LAST = 3'(RD_LAT - 1);

    state_t              state_q;
    logic [ADDR_W:0]     rem_q;
    logic [2:0]          drn_q;
    logic [RD_LAT-1:0]   vld_pipe_q;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                mode_q;
    logic                busy_q, done_q, aborted_q, rd_en_q, sum_ok_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   checksum_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [ADDR_W:0]     n_len;
    logic [ADDR_W-1:0]   first_addr;

    assign n_len      = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
    assign first_addr = ADDR_W'(32'(bus.base_addr) % DEPTH);

    // The oldest pipeline slot lines up with the RAM data of the matching read.
    always_comb begin
        acc_d = acc_q;
        if (vld_pipe_q[RD_LAT-1]) acc_d = acc_q + bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            drn_q      <= '0;
            vld_pipe_q <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            sum_ok_q   <= 1'b0;
            addr_q     <= '0;
            checksum_q <= '0;
            cnt_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            vld_pipe_q <= (vld_pipe_q << 1) | RD_LAT'(rd_en_q);
            acc_q      <= acc_d;
            if (busy_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_q     <= bus.mode;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        vld_pipe_q <= '0;
                        if (n_len == '0) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            checksum_q <= '0;
                            sum_ok_q   <= bus.mode;
                        end else begin
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                            addr_q  <= first_addr;
                            rem_q   <= n_len;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        rd_en_q    <= 1'b0;
                        aborted_q  <= 1'b1;
                        vld_pipe_q <= '0;
                    end else if (rem_q == REM_ONE) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                        drn_q   <= '0;
                    end else begin
                        rem_q  <= rem_q - REM_ONE;
                        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        aborted_q  <= 1'b1;
                        vld_pipe_q <= '0;
                    end else if (drn_q == DRN_LAST) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        checksum_q <= ~acc_d + DATA_W'(1);
                        sum_ok_q   <= mode_q & (acc_d == '0);
                    end else begin
                        drn_q <= drn_q + 3'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.checksum    = checksum_q;
    assign bus.sum_ok      = sum_ok_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_checksum_engine.sv
// Drives an RD_LAT=1 and an RD_LAT=3 engine with the same directed runs; per-instance
// monitors pop expected addresses and completion records from scoreboard queues.
module tb_checksum_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst3_n;
    int   cyc = 0, e0 = 0, checks = 0, errors = 0;
    int   bc1 = 0, bc3 = 0, nb1, nb3;

    typedef struct {
        bit         abrt;
        logic [7:0] ck;
        logic       ok;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t       eq1[$], eq3[$];
    logic [3:0] aq1[$], aq3[$];
    logic [7:0] mem [16];
    logic [7:0] rp1;
    logic [7:0] rp3 [3];

    checksum_engine_if #(.ADDR_W(4), .DATA_W(8), .CNT_W(16)) if1();
    checksum_engine_if #(.ADDR_W(4), .DATA_W(8), .CNT_W(16)) if3();

    checksum_engine #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .bus(if1));
    checksum_engine #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset_n(rst_n & rst3_n), .bus(if3));

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM models with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        if (if1.mem_rd_en) rp1 <= mem[if1.mem_addr];
        if (if3.mem_rd_en) rp3[0] <= mem[if3.mem_addr];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign if1.mem_rdata = rp1;
    assign if3.mem_rdata = rp3[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: output seen with nothing expected", nm);
    endtask

    task automatic mon(input int id, input logic rst, input logic busy, input logic rd,
                       input logic dn, input logic ab, input logic [3:0] addr,
                       input logic [7:0] ck, input logic ok, input logic [15:0] cnt,
                       input int bc, output int nbc);
        string      p;
        logic [3:0] ea;
        exp_t       e;
        bit         have;
        p = $sformatf("d%0d_", id);
        if (rd) begin
            have = (id == 1) ? (aq1.size() > 0) : (aq3.size() > 0);
            if (!have) fail_evt({p, "mem_read"});
            else begin
                ea = (id == 1) ? aq1.pop_front() : aq3.pop_front();
                chk({p, "mem_addr"}, 32'(addr), 32'(ea));
            end
        end
        nbc = busy ? bc + 1 : bc;
        if (!rst) nbc = 0;
        else if (dn || ab) begin
            have = (id == 1) ? (eq1.size() > 0) : (eq3.size() > 0);
            if (!have) fail_evt({p, "done_or_aborted"});
            else begin
                e = (id == 1) ? eq1.pop_front() : eq3.pop_front();
                chk({p, "aborted"},     32'(ab),  32'(e.abrt));
                chk({p, "done"},        32'(dn),  32'(!e.abrt));
                chk({p, "checksum"},    32'(ck),  32'(e.ck));
                chk({p, "sum_ok"},      32'(ok),  32'(e.ok));
                chk({p, "cycle_count"}, 32'(cnt), 32'(e.cnt));
                chk({p, "pulse_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({p, "busy_cycles"}, 32'(bc),  32'(e.cnt));
            end
            nbc = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(1, rst_n, if1.busy, if1.mem_rd_en, if1.done, if1.aborted, if1.mem_addr,
            if1.checksum, if1.sum_ok, if1.cycle_count, bc1, nb1);
        bc1 <= nb1;
    end

    always @(negedge clk) begin
        mon(3, rst_n & rst3_n, if3.busy, if3.mem_rd_en, if3.done, if3.aborted, if3.mem_addr,
            if3.checksum, if3.sum_ok, if3.cycle_count, bc3, nb3);
        bc3 <= nb3;
    end

    task automatic chk_zero(input int id);
        if (id == 1) begin
            chk("d1_reset_outs", {15'd0, if1.busy, if1.done, if1.aborted, if1.mem_rd_en,
                                  if1.mem_addr, if1.checksum, if1.sum_ok}, 32'd0);
            chk("d1_reset_count", 32'(if1.cycle_count), 32'd0);
        end else begin
            chk("d3_reset_outs", {15'd0, if3.busy, if3.done, if3.aborted, if3.mem_rd_en,
                                  if3.mem_addr, if3.checksum, if3.sum_ok}, 32'd0);
            chk("d3_reset_count", 32'(if3.cycle_count), 32'd0);
        end
    endtask

    task automatic drive(input bit st, input bit ab, input bit md, input int base, input int len);
        if1.start = st;  if3.start = st;
        if1.abort = ab;  if3.abort = ab;
        if1.mode  = md;  if3.mode  = md;
        if1.base_addr = 4'(base);  if3.base_addr = 4'(base);
        if1.length    = 5'(len);   if3.length    = 5'(len);
    endtask

    // d1/d3: cycle of the done/aborted pulse counting the start edge as 0; c1/c3: cycle_count.
    // ab: abort cycle (0 = none, also re-asserts start in cycle 3); rs: RD_LAT=3 reset cycle.
    task automatic run(input bit md, input int base, input int len, input logic [7:0] ck,
                       input bit ok, input int d1, input int c1, input int d3, input int c3,
                       input int ab, input int rs);
        int   n, k1, k3;
        exp_t e;
        n  = (len > 16) ? 16 : len;
        k1 = (ab != 0) ? ab : n;
        k3 = (ab != 0) ? ab : ((rs != 0) ? rs : n);
        drive(1'b1, 1'b0, md, base, len);
        @(posedge clk); #1;
        e0 = cyc;
        drive(1'b0, 1'b0, md, base, len);
        e.abrt = (ab != 0);
        e.ck   = ck;
        e.ok   = ok;
        e.cnt = c1; e.cyc = e0 + d1 - 1; eq1.push_back(e);
        if (rs == 0) begin
            e.cnt = c3; e.cyc = e0 + d3 - 1; eq3.push_back(e);
        end
        for (int i = 0; i < k1; i++) aq1.push_back(4'((base + i) % 16));
        for (int i = 0; i < k3; i++) aq3.push_back(4'((base + i) % 16));
        for (int k = 1; k <= 24; k++) begin
            if (rs != 0 && k == rs + 1) chk_zero(3);
            drive((ab != 0 && k == 3), (ab != 0 && k == ab), md, base, len);
            rst3_n = !(rs != 0 && k == rs);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, md, base, len);
        rst3_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        rst_n  = 1'b0;
        rst3_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(1);
        chk_zero(3);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 0, 16, 8'h78, 1'b0, 18, 17, 20, 19, 0, 0);
        mem[15] = 8'h88;
        run(1'b1, 0, 16, 8'h00, 1'b1, 18, 17, 20, 19, 0, 0);
        mem[15] = 8'h10;
        run(1'b0, 14, 4, 8'hDE, 1'b0, 6, 5, 8, 7, 0, 0);
        run(1'b0, 14, 20, 8'h78, 1'b0, 18, 17, 20, 19, 0, 0);
        run(1'b0, 0, 16, 8'h78, 1'b0, 6, 5, 6, 5, 5, 0);
        run(1'b0, 2, 3, 8'hF4, 1'b0, 5, 4, 7, 6, 0, 0);
        run(1'b0, 0, 16, 8'h78, 1'b0, 18, 17, 20, 19, 0, 8);
        run(1'b1, 0, 0, 8'h00, 1'b1, 1, 0, 1, 0, 0, 0);
        run(1'b0, 14, 4, 8'hDE, 1'b0, 6, 5, 8, 7, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("d1_pending_results", 32'(eq1.size()), 32'd0);
        chk("d3_pending_results", 32'(eq3.size()), 32'd0);
        chk("d1_pending_reads",   32'(aq1.size()), 32'd0);
        chk("d3_pending_reads",   32'(aq3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
